lpc_io_target: RTL and testbench

//  Data-provider stage directly downstream of lpc_periph. Decodes the 16-bit LPC I/O address and

---
 rtl/lpc_io_target.sv | 218 +++++++++++++++++++++
 tb/tb_lpc_io_target.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_io_target.sv
// LPC I/O target: decodes host I/O cycles from lpc_periph, serves a small register bank,
// captures port-80h POST codes into a FIFO and drives the IRQ number/request back upstream.
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR   = 16'h0F00,
    parameter logic [15:0] POST_ADDR   = 16'h0080,
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] lpc_addr_i,
    input  logic [7:0]  lpc_wdata_i,
    input  logic        lpc_data_wr_i,
    output logic        lpc_wr_done_o,
    input  logic        lpc_data_req_i,
    output logic        lpc_data_rd_o,
    output logic [7:0]  lpc_rdata_o,
    output logic [3:0]  irq_num_o,
    output logic        interrupt_o,
    output logic [7:0]  post_data_o,
    output logic        post_valid_o,
    input  logic        post_pop_i,
    input  logic        doorbell_i
);

    localparam int unsigned   DEPTH   = 1 << FIFO_AW;
    localparam int unsigned   CW      = FIFO_AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [3:0]    WAIT_C  = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_WAIT,
        S_WR_ACK,
        S_RD_WAIT,
        S_RD_ACK
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;

    logic [7:0]           r_scratch0;
    logic [7:0]           r_scratch1;
    logic                 r_irq_en;
    logic [3:0]           r_irq_num;
    logic                 r_pending;
    logic                 r_ovf;
    logic [7:0]           r_last_post;

    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr;
    logic [FIFO_AW-1:0]   r_rptr;
    logic [CW-1:0]        r_count;

    logic                 w_win_hit;
    logic                 w_post_hit;
    logic [2:0]           w_off;
    logic                 w_full;
    logic                 w_empty;
    logic [7:0]           w_rdata;
    logic                 w_commit;
    logic                 w_reg_wr;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_push_ok;
    logic                 w_ovf_set;
    logic                 w_ovf_clr;
    logic                 w_pend_clr;

    assign w_win_hit  = (lpc_addr_i[15:3] == BASE_ADDR[15:3]);
    assign w_post_hit = (lpc_addr_i == POST_ADDR);
    assign w_off      = lpc_addr_i[2:0];
    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);

    // A write takes effect only on the edge that raises the ack
    assign w_commit   = (r_state == S_WR_WAIT) && lpc_data_wr_i && (r_cnt == 4'd0);
    assign w_reg_wr   = w_commit && w_win_hit;
    assign w_push     = w_commit && !w_win_hit && w_post_hit;
    assign w_pop      = post_pop_i && !w_empty;
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_ovf_set  = w_push && w_full && !w_pop;
    assign w_ovf_clr  = w_reg_wr && (w_off == 3'd2) && lpc_wdata_i[5];
    assign w_pend_clr = w_reg_wr && (w_off == 3'd4) && lpc_wdata_i[0];

    assign irq_num_o    = r_irq_num;
    assign post_data_o  = r_mem[r_rptr];
    assign post_valid_o = !w_empty;

    // Read data selected by the current address
    always_comb begin
        w_rdata = 8'hFF;
        if (w_win_hit) begin
            case (w_off)
                3'd0:    w_rdata = r_scratch0;
                3'd1:    w_rdata = r_scratch1;
                3'd2:    w_rdata = {w_full, w_empty, r_ovf, 5'(r_count)};
                3'd3:    w_rdata = {r_irq_en, 3'b000, r_irq_num};
                3'd4:    w_rdata = {7'b0000000, r_pending};
                3'd5:    w_rdata = 8'hA5;
                default: w_rdata = 8'hFF;
            endcase
        end else if (w_post_hit) begin
            w_rdata = r_last_post;
        end
    end

    // Bus handshake FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            lpc_wr_done_o <= 1'b0;
            lpc_data_rd_o <= 1'b0;
            lpc_rdata_o   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lpc_data_wr_i) begin
                        r_state <= S_WR_WAIT;
                        r_cnt   <= WAIT_C;
                    end else if (lpc_data_req_i) begin
                        r_state <= S_RD_WAIT;
                        r_cnt   <= WAIT_C;
                    end
                end
                S_WR_WAIT: begin
                    if (!lpc_data_wr_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        lpc_wr_done_o <= 1'b1;
                        r_state       <= S_WR_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WR_ACK: begin
                    if (!lpc_data_wr_i) begin
                        lpc_wr_done_o <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_RD_WAIT: begin
                    if (!lpc_data_req_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        lpc_rdata_o   <= w_rdata;
                        lpc_data_rd_o <= 1'b1;
                        r_state       <= S_RD_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RD_ACK: begin
                    if (!lpc_data_req_i) begin
                        lpc_data_rd_o <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register bank, POST FIFO and interrupt request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scratch0  <= 8'h00;
            r_scratch1  <= 8'h00;
            r_irq_en    <= 1'b0;
            r_irq_num   <= 4'd0;
            r_pending   <= 1'b0;
            r_ovf       <= 1'b0;
            r_last_post <= 8'h00;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            interrupt_o <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_reg_wr) begin
                case (w_off)
                    3'd0: r_scratch0 <= lpc_wdata_i;
                    3'd1: r_scratch1 <= lpc_wdata_i;
                    3'd3: begin
                        r_irq_en  <= lpc_wdata_i[7];
                        r_irq_num <= lpc_wdata_i[3:0];
                    end
                    default: ;
                endcase
            end

            // Doorbell wins over a same-cycle W1C clear
            r_pending   <= (r_pending & ~w_pend_clr) | doorbell_i;
            r_ovf       <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
            interrupt_o <= r_irq_en & r_pending;

            if (w_push) begin
                r_last_post <= lpc_wdata_i;
            end
            if (w_push_ok) begin
                r_mem[r_wptr] <= lpc_wdata_i;
                r_wptr        <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lpc_io_target.sv
// Self-checking bench for lpc_io_target: vector table, directed corner sequences and a
// randomized phase checked against a queue-based behavioural model.
module tb_lpc_io_target;

    localparam int WS  = 2;
    localparam int WS4 = 4;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr;
    logic        req;
    logic        pop;
    logic        db;
    logic        wr_done;
    logic        rd;
    logic [7:0]  rdata;
    logic [3:0]  irq_num;
    logic        intr;
    logic [7:0]  post_data;
    logic        post_valid;

    logic [15:0] addr4;
    logic        req4;
    logic        wr4;
    logic [7:0]  wdata4;
    logic        pop4;
    logic        db4;
    logic        wr_done4;
    logic        rd4;
    logic [7:0]  rdata4;
    logic [3:0]  irq_num4;
    logic        intr4;
    logic [7:0]  post_data4;
    logic        post_valid4;

    int n_checks = 0;
    int n_err    = 0;

    lpc_io_target #(.WAIT_STATES(WS)) u_dut (
        .clk_i(clk), .rst_i(rst), .lpc_addr_i(addr), .lpc_wdata_i(wdata),
        .lpc_data_wr_i(wr), .lpc_wr_done_o(wr_done), .lpc_data_req_i(req),
        .lpc_data_rd_o(rd), .lpc_rdata_o(rdata), .irq_num_o(irq_num),
        .interrupt_o(intr), .post_data_o(post_data), .post_valid_o(post_valid),
        .post_pop_i(pop), .doorbell_i(db)
    );

    lpc_io_target #(.WAIT_STATES(WS4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .lpc_addr_i(addr4), .lpc_wdata_i(wdata4),
        .lpc_data_wr_i(wr4), .lpc_wr_done_o(wr_done4), .lpc_data_req_i(req4),
        .lpc_data_rd_o(rd4), .lpc_rdata_o(rdata4), .irq_num_o(irq_num4),
        .interrupt_o(intr4), .post_data_o(post_data4), .post_valid_o(post_valid4),
        .post_pop_i(pop4), .doorbell_i(db4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the register map and POST FIFO
    logic [7:0] m_scr [2];
    logic [7:0] m_q [$];
    logic       m_ovf;
    logic       m_en;
    logic [3:0] m_num;
    logic       m_pend;
    logic [7:0] m_last;

    function automatic void m_reset();
        m_scr[0] = 8'h00;
        m_scr[1] = 8'h00;
        m_q.delete();
        m_ovf  = 1'b0;
        m_en   = 1'b0;
        m_num  = 4'd0;
        m_pend = 1'b0;
        m_last = 8'h00;
    endfunction

    function automatic void m_write(input logic [15:0] a, input logic [7:0] d);
        if (a >= 16'h0F00 && a <= 16'h0F07) begin
            case (a - 16'h0F00)
                16'd0: m_scr[0] = d;
                16'd1: m_scr[1] = d;
                16'd2: if (d[5]) m_ovf = 1'b0;
                16'd3: begin m_en = d[7]; m_num = d[3:0]; end
                16'd4: if (d[0]) m_pend = 1'b0;
                default: ;
            endcase
        end else if (a == 16'h0080) begin
            m_last = d;
            if (m_q.size() < 16) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        int n;
        n = m_q.size();
        if (a >= 16'h0F00 && a <= 16'h0F07) begin
            case (a - 16'h0F00)
                16'd0: return m_scr[0];
                16'd1: return m_scr[1];
                16'd2: return {(n == 16), (n == 0), m_ovf, 5'(n)};
                16'd3: return {m_en, 3'b000, m_num};
                16'd4: return {7'd0, m_pend};
                16'd5: return 8'hA5;
                default: return 8'hFF;
            endcase
        end
        if (a == 16'h0080) return m_last;
        return 8'hFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: no ack within cycle budget", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; req = 1'b0; pop = 1'b0; db = 1'b0; req4 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_reset();
        chk("rst wr_done", 32'(wr_done), 0);
        chk("rst rd", 32'(rd), 0);
        chk("rst rdata", 32'(rdata), 0);
        chk("rst irq_num", 32'(irq_num), 0);
        chk("rst interrupt", 32'(intr), 0);
        chk("rst post_valid", 32'(post_valid), 0);
        chk("rst post_data", 32'(post_data), 0);
    endtask

    // Host write; optional doorbell/pop pulse lined up with the commit edge
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                             input logic dbc, input logic ppc, input int hold);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        addr = a; wdata = d; wr = 1'b1;
        while (n < 40) begin
            tick();
            n++;
            db = 1'b0;
            pop = 1'b0;
            if (wr_done) begin ok = 1'b1; break; end
            if (n == WS + 1) begin db = dbc; pop = ppc; end
        end
        if (!ok) begin
            timeout("wr ack");
        end else begin
            chk("wr latency", 32'(n), 32'(WS + 2));
            repeat (hold) tick();
            if (hold > 0) chk("wr_done hold", 32'(wr_done), 1);
        end
        if (ppc && m_q.size() > 0) void'(m_q.pop_front());
        m_write(a, d);
        if (dbc) m_pend = 1'b1;
        wr = 1'b0;
        tick();
        chk("wr_done drop", 32'(wr_done), 0);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        d = 8'hxx;
        addr = a; req = 1'b1;
        while (n < 40) begin
            tick();
            n++;
            if (rd) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            timeout("rd ack");
        end else begin
            chk("rd latency", 32'(n), 32'(WS + 2));
            d = rdata;
        end
        req = 1'b0;
        tick();
        chk("rd drop", 32'(rd), 0);
        chk("rdata held", 32'(rdata), 32'(d));
    endtask

    task automatic pop_one(output logic [7:0] d);
        chk("post_valid", 32'(post_valid), 32'(m_q.size() != 0));
        d = post_data;
        if (m_q.size() > 0) chk("post_data", 32'(post_data), 32'(m_q[0]));
        pop = 1'b1;
        tick();
        pop = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp;
    } vec_t;

    vec_t        vt[$];
    logic [7:0]  d;
    logic [15:0] ra;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        addr = 16'h0; wdata = 8'h0; wr = 1'b0; req = 1'b0; pop = 1'b0; db = 1'b0; rst = 1'b1;
        addr4 = 16'h0; req4 = 1'b0; wr4 = 1'b0; wdata4 = 8'h0; pop4 = 1'b0; db4 = 1'b0;

        vt.push_back('{1'b1, 16'h0F00, 8'h5A, 8'h00});
        vt.push_back('{1'b0, 16'h0F00, 8'h00, 8'h5A});
        vt.push_back('{1'b1, 16'h0F01, 8'hC3, 8'h00});
        vt.push_back('{1'b0, 16'h0F01, 8'h00, 8'hC3});
        vt.push_back('{1'b0, 16'h0F05, 8'h00, 8'hA5});
        vt.push_back('{1'b0, 16'h0F06, 8'h00, 8'hFF});
        vt.push_back('{1'b1, 16'h0F07, 8'h12, 8'h00});
        vt.push_back('{1'b0, 16'h0F07, 8'h00, 8'hFF});
        vt.push_back('{1'b0, 16'h0300, 8'h00, 8'hFF});
        vt.push_back('{1'b1, 16'h0F03, 8'h87, 8'h00});
        vt.push_back('{1'b0, 16'h0F03, 8'h00, 8'h87});
        vt.push_back('{1'b1, 16'h0F03, 8'hFF, 8'h00});
        vt.push_back('{1'b0, 16'h0F03, 8'h00, 8'h8F});
        vt.push_back('{1'b0, 16'h0F02, 8'h00, 8'h40});
        vt.push_back('{1'b0, 16'h0080, 8'h00, 8'h00});
        vt.push_back('{1'b1, 16'h0080, 8'h3C, 8'h00});
        vt.push_back('{1'b0, 16'h0080, 8'h00, 8'h3C});
        vt.push_back('{1'b0, 16'h0F02, 8'h00, 8'h01});
        vt.push_back('{1'b0, 16'h0F04, 8'h00, 8'h00});

        do_reset();
        foreach (vt[i]) begin
            if (vt[i].wr) begin
                bus_write(vt[i].addr, vt[i].data, 1'b0, 1'b0, 0);
            end else begin
                bus_read(vt[i].addr, d);
                chk($sformatf("vec%0d rd %h", i, vt[i].addr), 32'(d), 32'(vt[i].exp));
            end
        end

        // Ack latency and hold, then read back
        do_reset();
        bus_write(16'h0F00, 8'h5A, 1'b0, 1'b0, 3);
        bus_read(16'h0F00, d);
        chk("t1 rd 0F00", 32'(d), 32'h5A);

        // POST FIFO overflow, drain order, W1C of ovf
        do_reset();
        for (int i = 0; i < 17; i++) bus_write(16'h0080, 8'(i), 1'b0, 1'b0, 0);
        bus_read(16'h0F02, d);
        chk("t2 status full", 32'(d), 32'hB0);
        for (int i = 0; i < 16; i++) begin
            pop_one(d);
            chk("t2 pop order", 32'(d), 32'(i));
        end
        pop_one(d);
        bus_read(16'h0F02, d);
        chk("t2 status empty", 32'(d), 32'h60);
        bus_write(16'h0F02, 8'h20, 1'b0, 1'b0, 0);
        bus_read(16'h0F02, d);
        chk("t2 status cleared", 32'(d), 32'h40);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < 16; i++) bus_write(16'h0080, 8'(8'h40 + i), 1'b0, 1'b0, 0);
        chk("t3 head", 32'(post_data), 32'h40);
        bus_write(16'h0080, 8'h99, 1'b0, 1'b1, 0);
        bus_read(16'h0F02, d);
        chk("t3 status", 32'(d), 32'h90);
        for (int i = 0; i < 16; i++) begin
            pop_one(d);
            chk("t3 order", 32'(d), (i == 15) ? 32'h99 : 32'(8'h41 + i));
        end

        // Interrupt lag, W1C clear, doorbell beating the clear
        do_reset();
        bus_write(16'h0F03, 8'h87, 1'b0, 1'b0, 0);
        chk("t4 irq_num", 32'(irq_num), 7);
        chk("t4 intr idle", 32'(intr), 0);
        db = 1'b1;
        tick();
        db = 1'b0;
        m_pend = 1'b1;
        chk("t4 intr lag", 32'(intr), 0);
        tick();
        chk("t4 intr set", 32'(intr), 1);
        bus_write(16'h0F04, 8'h01, 1'b0, 1'b0, 0);
        chk("t4 intr cleared", 32'(intr), 0);
        bus_write(16'h0F04, 8'h01, 1'b1, 1'b0, 0);
        chk("t4 doorbell wins", 32'(intr), 1);
        bus_read(16'h0F04, d);
        chk("t4 status", 32'(d), 32'h01);

        // Aborted read on the 4-wait-state instance, then a full read
        begin
            int  n;
            bit  seen;
            seen = 1'b0;
            addr4 = 16'h0F05;
            req4 = 1'b1;
            tick();
            tick();
            req4 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (rd4) seen = 1'b1;
            end
            chk("t5 abort no rd", 32'(seen), 0);
            req4 = 1'b1;
            n = 0;
            seen = 1'b0;
            while (n < 40) begin
                tick();
                n++;
                if (rd4) begin seen = 1'b1; break; end
            end
            if (!seen) timeout("t5 rd ack");
            else begin
                chk("t5 latency", 32'(n), 32'(WS4 + 2));
                chk("t5 rdata", 32'(rdata4), 32'hA5);
            end
            req4 = 1'b0;
            tick();
            chk("t5 rd drop", 32'(rd4), 0);
        end

        // Reset on the would-be commit edge drops the write
        do_reset();
        addr = 16'h0F01; wdata = 8'h77; wr = 1'b1;
        tick();
        tick();
        tick();
        chk("t6 no ack yet", 32'(wr_done), 0);
        rst = 1'b1;
        tick();
        chk("t6 wr_done after rst", 32'(wr_done), 0);
        rst = 1'b0;
        wr = 1'b0;
        tick();
        m_reset();
        bus_read(16'h0F01, d);
        chk("t6 scratch1", 32'(d), 0);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 5))
                0, 4: begin
                    case ($urandom_range(0, 3))
                        0, 1:    ra = 16'h0F00 + 16'($urandom_range(0, 7));
                        2:       ra = 16'h0080;
                        default: ra = 16'h1000 + 16'($urandom_range(0, 4095));
                    endcase
                    if (ra == 16'h0080 && m_q.size() == 16) ra = 16'h0F00;
                    bus_write(ra, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
                end
                1: begin
                    case ($urandom_range(0, 3))
                        0, 1:    ra = 16'h0F00 + 16'($urandom_range(0, 7));
                        2:       ra = 16'h0080;
                        default: ra = 16'h1000 + 16'($urandom_range(0, 4095));
                    endcase
                    bus_read(ra, d);
                    chk($sformatf("rnd rd %h", ra), 32'(d), 32'(m_read(ra)));
                end
                2: pop_one(d);
                3: begin
                    db = 1'b1;
                    tick();
                    db = 1'b0;
                    m_pend = 1'b1;
                    tick();
                end
                default: begin
                    bus_read(16'h0F02, d);
                    chk("rnd status", 32'(d), 32'(m_read(16'h0F02)));
                end
            endcase
            chk("rnd irq_num", 32'(irq_num), 32'(m_num));
            chk("rnd interrupt", 32'(intr), 32'(m_en & m_pend));
            chk("rnd post_valid", 32'(post_valid), 32'(m_q.size() != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
